// File: rtl/serial_link_partner.sv
// rtl/serial_link_partner.sv - far-end serial partner for the processor's software-driven serial pins
module serial_link_partner #(
  parameter int DATA_W     = 16,
  parameter int BIT_CYCLES = 8,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              serial_in,
  output logic              serial_out,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              rx_overrun,
  output logic              frame_err
);
  localparam int CNT_W = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BIT_CYCLES / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic sync1_q, s_in_q;

  state_t            rx_state_q, rx_state_d;
  logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
  logic [IDX_W-1:0]  rx_idx_q, rx_idx_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
  logic              rx_wait_q, rx_wait_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              rx_ovr_q, rx_ovr_d;
  logic              ferr_q, ferr_d;

  state_t            tx_state_q, tx_state_d;
  logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
  logic [IDX_W-1:0]  tx_idx_q, tx_idx_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic              tx_out_q, tx_out_d;

  logic              tx_bit;
  logic [DATA_W-1:0] tx_shift_nxt;
  logic [DATA_W-1:0] rx_shift_nxt;

  assign tx_bit       = MSB_FIRST ? tx_shift_q[DATA_W-1] : tx_shift_q[0];
  assign tx_shift_nxt = MSB_FIRST ? {tx_shift_q[DATA_W-2:0], 1'b0} : {1'b0, tx_shift_q[DATA_W-1:1]};
  assign rx_shift_nxt = MSB_FIRST ? {rx_shift_q[DATA_W-2:0], s_in_q} : {s_in_q, rx_shift_q[DATA_W-1:1]};

  // two-flop synchronizer; every receive decision uses s_in_q
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      s_in_q  <= 1'b0;
    end else begin
      sync1_q <= serial_in;
      s_in_q  <= sync1_q;
    end
  end

  // receive state and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
      rx_wait_q  <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_ovr_q   <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_shift_q <= rx_shift_d;
      rx_wait_q  <= rx_wait_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_ovr_q   <= rx_ovr_d;
      ferr_q     <= ferr_d;
    end
  end

  // receive next state: mid-bit sampling, commit or overrun at the stop sample
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_idx_d   = rx_idx_q;
    rx_shift_d = rx_shift_q;
    rx_wait_d  = rx_wait_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q & ~rx_ready;
    rx_ovr_d   = 1'b0;
    ferr_d     = 1'b0;
    case (rx_state_q)
      S_IDLE: begin
        if (s_in_q) begin
          rx_state_d = S_START;
          rx_cnt_d   = CNT_HALF;
        end
      end
      S_START: begin
        if (rx_cnt_q != '0) begin
          rx_cnt_d = rx_cnt_q - CNT_ONE;
        end else if (s_in_q) begin
          rx_state_d = S_DATA;
          rx_cnt_d   = CNT_FULL;
          rx_idx_d   = '0;
        end else begin
          rx_state_d = S_IDLE;
        end
      end
      S_DATA: begin
        if (rx_cnt_q != '0) begin
          rx_cnt_d = rx_cnt_q - CNT_ONE;
        end else begin
          rx_shift_d = rx_shift_nxt;
          rx_cnt_d   = CNT_FULL;
          if (rx_idx_q == IDX_LAST) rx_state_d = S_STOP;
          else                      rx_idx_d   = rx_idx_q + IDX_ONE;
        end
      end
      S_STOP: begin
        if (rx_wait_q) begin
          // bad stop bit seen: hold here until the line returns to idle
          if (!s_in_q) begin
            rx_wait_d  = 1'b0;
            rx_state_d = S_IDLE;
          end
        end else if (rx_cnt_q != '0) begin
          rx_cnt_d = rx_cnt_q - CNT_ONE;
        end else if (!s_in_q) begin
          rx_state_d = S_IDLE;
          if (!rx_valid_q || rx_ready) begin
            rx_data_d  = rx_shift_q;
            rx_valid_d = 1'b1;
          end else begin
            rx_ovr_d = 1'b1;
          end
        end else begin
          ferr_d    = 1'b1;
          rx_wait_d = 1'b1;
        end
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  // receive outputs come straight from registers
  always_comb begin
    rx_data    = rx_data_q;
    rx_valid   = rx_valid_q;
    rx_overrun = rx_ovr_q;
    frame_err  = ferr_q;
  end

  // transmit state and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_shift_q <= '0;
      tx_out_q   <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_shift_q <= tx_shift_d;
      tx_out_q   <= tx_out_d;
    end
  end

  // transmit next state: each line bit is held for BIT_CYCLES clocks
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_idx_d   = tx_idx_q;
    tx_shift_d = tx_shift_q;
    tx_out_d   = tx_out_q;
    case (tx_state_q)
      S_IDLE: begin
        tx_out_d = 1'b0;
        if (tx_valid) begin
          tx_shift_d = tx_data;
          tx_state_d = S_START;
          tx_cnt_d   = CNT_FULL;
          tx_out_d   = 1'b1;
        end
      end
      S_START: begin
        if (tx_cnt_q != '0) begin
          tx_cnt_d = tx_cnt_q - CNT_ONE;
        end else begin
          tx_state_d = S_DATA;
          tx_cnt_d   = CNT_FULL;
          tx_idx_d   = '0;
          tx_out_d   = tx_bit;
          tx_shift_d = tx_shift_nxt;
        end
      end
      S_DATA: begin
        if (tx_cnt_q != '0) begin
          tx_cnt_d = tx_cnt_q - CNT_ONE;
        end else begin
          tx_cnt_d = CNT_FULL;
          if (tx_idx_q == IDX_LAST) begin
            tx_state_d = S_STOP;
            tx_out_d   = 1'b0;
          end else begin
            tx_idx_d   = tx_idx_q + IDX_ONE;
            tx_out_d   = tx_bit;
            tx_shift_d = tx_shift_nxt;
          end
        end
      end
      S_STOP: begin
        if (tx_cnt_q != '0) tx_cnt_d   = tx_cnt_q - CNT_ONE;
        else                tx_state_d = S_IDLE;
      end
      default: tx_state_d = S_IDLE;
    endcase
  end

  // transmit outputs: ready only when idle, line driven from a flop
  always_comb begin
    tx_ready   = (tx_state_q == S_IDLE);
    serial_out = tx_out_q;
  end

endmodule

// File: tb/tb_serial_link_partner.sv
// tb/tb_serial_link_partner.sv - randomized self-checking bench for serial_link_partner
module tb_serial_link_partner;
  localparam int DW = 16;
  localparam int BC = 8;

  logic clk = 1'b0;
  logic reset, serial_in, rx_ready, tx_valid;
  logic [DW-1:0] tx_data;
  logic serial_out, rx_valid, tx_ready, rx_overrun, frame_err;
  logic [DW-1:0] rx_data;
  logic l_serial_out, l_rx_valid, l_tx_ready, l_rx_overrun, l_frame_err;
  logic [DW-1:0] l_rx_data;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [DW-1:0] exp_m[$];
  logic [DW-1:0] exp_l[$];
  logic tq_m[$];
  logic tq_l[$];
  int exp_ferr = 0, exp_ovr = 0;
  int ferr_m = 0, ferr_l = 0, ovr_m = 0, ovr_l = 0;
  int vcyc = 0, rise_cyc = 0, stop_cyc = 0;
  logic rxv_prev = 1'b0;
  logic rx_done = 1'b0;

  serial_link_partner #(.DATA_W(DW), .BIT_CYCLES(BC), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .reset(reset), .serial_in(serial_in), .serial_out(serial_out),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_overrun(rx_overrun), .frame_err(frame_err));

  serial_link_partner #(.DATA_W(DW), .BIT_CYCLES(BC), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset(reset), .serial_in(serial_in), .serial_out(l_serial_out),
    .rx_data(l_rx_data), .rx_valid(l_rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(l_tx_ready),
    .rx_overrun(l_rx_overrun), .frame_err(l_frame_err));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] rev(input logic [DW-1:0] w);
    logic [DW-1:0] r;
    for (int i = 0; i < DW; i++) r[i] = w[DW-1-i];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // expected line waveform of one transmitted frame, per clock, for both bit orders
  task automatic load_tx(input logic [DW-1:0] w);
    for (int b = 0; b < DW + 2; b++) begin
      logic bm, bl;
      if (b == 0) begin
        bm = 1'b1; bl = 1'b1;
      end else if (b == DW + 1) begin
        bm = 1'b0; bl = 1'b0;
      end else begin
        bm = w[DW-b]; bl = w[b-1];
      end
      repeat (BC) begin
        tq_m.push_back(bm);
        tq_l.push_back(bl);
      end
    end
  endtask

  // drive one frame MSB first; model decides commit / overrun / frame error at the stop bit
  task automatic send_rx(input logic [DW-1:0] w, input logic stop_bit);
    logic [DW+1:0] fr;
    fr = {1'b1, w, stop_bit};
    for (int b = DW + 1; b >= 0; b--) begin
      serial_in = fr[b];
      if (b == 0) begin
        stop_cyc = cyc;
        if (stop_bit) exp_ferr++;
        else if (exp_m.size() == 0) begin
          exp_m.push_back(w);
          exp_l.push_back(rev(w));
        end else exp_ovr++;
      end
      repeat (BC) tick();
    end
    serial_in = 1'b0;
  endtask

  task automatic send_tx(input logic [DW-1:0] w);
    int n;
    n = 0;
    tx_valid = 1'b0;
    while (tq_m.size() != 0 && n < 2000) begin
      tick();
      n++;
    end
    check_eq("tx_wait_idle", n < 2000, 1);
    tx_data = w;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    tx_data = DW'($urandom);
  endtask

  // monitor: receive handshakes, pulse counts and per-clock transmit line check
  always @(negedge clk) begin
    if (reset) begin
      tq_m.delete();
      tq_l.delete();
    end else begin
      if (rx_valid) vcyc++;
      if (rx_valid && !rxv_prev) rise_cyc = cyc;
      if (rx_valid && rx_ready) begin
        check_eq("rx_pending", exp_m.size() > 0, 1);
        if (exp_m.size() > 0) check_eq("rx_data", rx_data, exp_m.pop_front());
      end
      if (l_rx_valid && rx_ready) begin
        check_eq("rx_pending_lsb", exp_l.size() > 0, 1);
        if (exp_l.size() > 0) check_eq("rx_data_lsb", l_rx_data, exp_l.pop_front());
      end
      if (frame_err) ferr_m++;
      if (l_frame_err) ferr_l++;
      if (rx_overrun) ovr_m++;
      if (l_rx_overrun) ovr_l++;
      if (tq_m.size() > 0) begin
        check_eq("tx_line", serial_out, tq_m.pop_front());
        check_eq("tx_line_lsb", l_serial_out, tq_l.pop_front());
        check_eq("tx_busy", {tx_ready, l_tx_ready}, 2'b00);
      end else begin
        check_eq("tx_idle_line", {serial_out, l_serial_out}, 2'b00);
        check_eq("tx_idle_ready", {tx_ready, l_tx_ready}, 2'b11);
        if (tx_valid) load_tx(tx_data);
      end
    end
    rxv_prev = rx_valid;
  end

  initial begin
    int n, base;
    reset = 1'b1; serial_in = 1'b0; rx_ready = 1'b0; tx_valid = 1'b0; tx_data = '0;
    repeat (3) tick();
    check_eq("rst_rx_data", {rx_data, l_rx_data}, 0);
    check_eq("rst_rx_valid", {rx_valid, l_rx_valid}, 0);
    check_eq("rst_pulses", {rx_overrun, frame_err, l_rx_overrun, l_frame_err}, 0);
    check_eq("rst_serial_out", {serial_out, l_serial_out}, 0);
    check_eq("rst_tx_ready", {tx_ready, l_tx_ready}, 2'b11);
    reset = 1'b0;

    repeat (500) tick();
    check_eq("idle_rx_valid", vcyc, 0);
    check_eq("idle_pulses", ferr_m + ferr_l + ovr_m + ovr_l, 0);

    rx_ready = 1'b1;
    vcyc = 0;
    send_rx(16'hA5C3, 1'b0);
    repeat (12) tick();
    check_eq("a5c3_valid_cycles", vcyc, 1);
    check_eq("a5c3_latency_ok", (rise_cyc - stop_cyc >= 3) && (rise_cyc - stop_cyc <= 2 + BC/2 + 1), 1);
    check_eq("a5c3_delivered", exp_m.size() + exp_l.size(), 0);

    send_tx(16'h8001);
    n = 0;
    while (!tx_ready && n < 500) begin
      tick();
      n++;
    end
    check_eq("tx_8001_len", n, (DW + 2) * BC);

    rx_ready = 1'b0;
    base = ovr_m;
    send_rx(16'h1234, 1'b0);
    send_rx(16'h5678, 1'b0);
    repeat (4) tick();
    check_eq("ovr_rx_data", rx_data, 16'h1234);
    check_eq("ovr_rx_data_lsb", l_rx_data, rev(16'h1234));
    check_eq("ovr_rx_valid", rx_valid, 1);
    check_eq("ovr_pulses", ovr_m - base, 1);
    rx_ready = 1'b1;
    tick();
    tick();
    check_eq("ovr_valid_drop", {rx_valid, l_rx_valid}, 0);

    base = ferr_m;
    send_rx(DW'($urandom), 1'b1);
    repeat (6) tick();
    check_eq("ferr_pulses", ferr_m - base, 1);
    check_eq("ferr_no_valid", rx_valid, 0);
    send_rx(16'h00FF, 1'b0);
    repeat (12) tick();
    check_eq("ferr_recover", exp_m.size() + exp_l.size(), 0);

    vcyc = 0;
    serial_in = 1'b1;
    tick();
    tick();
    serial_in = 1'b0;
    repeat (200) tick();
    check_eq("glitch_no_rx", vcyc, 0);
    check_eq("glitch_no_ferr", ferr_m, exp_ferr);
    send_rx(DW'($urandom), 1'b0);
    repeat (12) tick();
    check_eq("glitch_recover", exp_m.size(), 0);

    // full duplex: random frames in, random words out, random host back-pressure
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          logic bad;
          bad = ($urandom_range(0, 5) == 0);
          send_rx(DW'($urandom), bad);
          repeat ($urandom_range(0, 12) + (bad ? 4 : 0)) tick();
        end
        rx_done = 1'b1;
      end
      begin
        int g;
        g = 0;
        while (!rx_done && g < 5000) begin
          rx_ready = 1'($urandom);
          tick();
          g++;
        end
      end
      begin
        for (int i = 0; i < 10; i++) begin
          int w;
          w = 0;
          while (tq_m.size() != 0 && w < 2000) begin
            if (tq_m.size() > 4) begin
              tx_valid = 1'($urandom);
              tx_data = DW'($urandom);
            end else tx_valid = 1'b0;
            tick();
            w++;
          end
          check_eq("rand_tx_wait", w < 2000, 1);
          tx_data = DW'($urandom);
          tx_valid = 1'b1;
          tick();
          tx_valid = 1'b0;
        end
      end
    join
    rx_ready = 1'b1;
    repeat (200) tick();
    check_eq("rand_rx_drained", exp_m.size() + exp_l.size(), 0);
    check_eq("rand_ferr", ferr_m, exp_ferr);
    check_eq("rand_ferr_lsb", ferr_l, exp_ferr);
    check_eq("rand_ovr", ovr_m, exp_ovr);
    check_eq("rand_ovr_lsb", ovr_l, exp_ovr);

    send_tx(DW'($urandom));
    repeat (3) tick();
    check_eq("mid_tx_start_bit", serial_out, 1);
    reset = 1'b1;
    tick();
    check_eq("mid_tx_rst_out", {serial_out, l_serial_out}, 0);
    check_eq("mid_tx_rst_ready", {tx_ready, l_tx_ready}, 2'b11);
    reset = 1'b0;
    repeat (20) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
